// File: rtl/w0rm_mem_arbiter.sv
// Single-port memory arbiter between an instruction fetcher and a data port.
// Data wins by default; a bounded data streak keeps a waiting fetch from starving.
module w0rm_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int INST_WIDTH      = 16,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_req,
  input  logic                  inst_flush,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic                  inst_valid,
  output logic                  inst_err,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wr_data,
  input  logic                  data_wr_en,
  input  logic                  data_req,
  output logic [DATA_WIDTH-1:0] data_rd_data,
  output logic                  data_done,
  output logic                  data_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  inst_hi_q, inst_hi_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  mem_req_q, mem_req_d;
  logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  inst_err_q, inst_err_d;
  logic [DATA_WIDTH-1:0] data_rd_data_q, data_rd_data_d;
  logic                  data_done_q, data_done_d;
  logic                  data_err_q, data_err_d;

  logic data_win_s, inst_win_s, to_hit_s;

  assign data_win_s = data_req && (!inst_req || inst_flush || (streak_q < STREAK_MAX));
  assign inst_win_s = inst_req && !inst_flush;
  assign to_hit_s   = (to_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_win_s) begin
          state_d = S_DATA;
        end else if (inst_win_s) begin
          state_d = S_INST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INST: begin
        if (mem_ack || to_hit_s) begin
          state_d = S_IDLE;
        end else if (inst_flush) begin
          state_d = S_DROP;
        end else begin
          state_d = S_INST;
        end
      end
      S_DATA, S_DROP: begin
        if (mem_ack || to_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    to_cnt_d       = to_cnt_q;
    inst_hi_d      = inst_hi_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    mem_wr_en_d    = mem_wr_en_q;
    mem_req_d      = mem_req_q;
    inst_data_d    = inst_data_q;
    inst_valid_d   = 1'b0;
    inst_err_d     = 1'b0;
    data_rd_data_d = data_rd_data_q;
    data_done_d    = 1'b0;
    data_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_win_s) begin
          mem_req_d     = 1'b1;
          mem_addr_d    = data_addr;
          mem_wr_data_d = data_wr_data;
          mem_wr_en_d   = data_wr_en;
          to_cnt_d      = '0;
        end else if (inst_win_s) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = inst_addr & WORD_MASK;
          mem_wr_en_d = 1'b0;
          inst_hi_d   = inst_addr[1];
          to_cnt_d    = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_INST: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!inst_flush) begin
            inst_valid_d = 1'b1;
            inst_data_d  = inst_hi_q ? mem_rd_data[DATA_WIDTH-1:INST_WIDTH]
                                     : mem_rd_data[INST_WIDTH-1:0];
          end else begin
            inst_valid_d = 1'b0;
          end
        end else if (to_hit_s) begin
          mem_req_d  = 1'b0;
          // A fetch flushed in its final cycle is dropped silently
          inst_err_d = !inst_flush;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DATA: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          data_done_d = 1'b1;
          if (!mem_wr_en_q) begin
            data_rd_data_d = mem_rd_data;
          end else begin
            data_rd_data_d = data_rd_data_q;
          end
        end else if (to_hit_s) begin
          mem_req_d  = 1'b0;
          data_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DROP: begin
        if (mem_ack || to_hit_s) begin
          mem_req_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  // Data streak counter: only data grants that overtake a waiting fetch count
  always_comb begin
    if (!inst_req) begin
      streak_d = '0;
    end else if ((state_q == S_IDLE) && data_win_s) begin
      streak_d = (streak_q < STREAK_MAX) ? streak_q + STREAK_W'(1) : streak_q;
    end else if ((state_q == S_IDLE) && inst_win_s) begin
      streak_d = '0;
    end else begin
      streak_d = streak_q;
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q       <= '0;
      to_cnt_q       <= '0;
      inst_hi_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_req_q      <= 1'b0;
      inst_data_q    <= '0;
      inst_valid_q   <= 1'b0;
      inst_err_q     <= 1'b0;
      data_rd_data_q <= '0;
      data_done_q    <= 1'b0;
      data_err_q     <= 1'b0;
    end else begin
      streak_q       <= streak_d;
      to_cnt_q       <= to_cnt_d;
      inst_hi_q      <= inst_hi_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_req_q      <= mem_req_d;
      inst_data_q    <= inst_data_d;
      inst_valid_q   <= inst_valid_d;
      inst_err_q     <= inst_err_d;
      data_rd_data_q <= data_rd_data_d;
      data_done_q    <= data_done_d;
      data_err_q     <= data_err_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_req      = mem_req_q;
  assign inst_data    = inst_data_q;
  assign inst_valid   = inst_valid_q;
  assign inst_err     = inst_err_q;
  assign data_rd_data = data_rd_data_q;
  assign data_done    = data_done_q;
  assign data_err     = data_err_q;

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Directed bench for w0rm_mem_arbiter: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed per scenario.
module tb_w0rm_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] inst_addr;
  logic        inst_req;
  logic        inst_flush;
  logic [15:0] inst_data;
  logic        inst_valid;
  logic        inst_err;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic        data_wr_en;
  logic        data_req;
  logic [31:0] data_rd_data;
  logic        data_done;
  logic        data_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rd_data;

  int checks;
  int errors;

  w0rm_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .INST_WIDTH(16),
    .MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_addr(inst_addr), .inst_req(inst_req), .inst_flush(inst_flush),
    .inst_data(inst_data), .inst_valid(inst_valid), .inst_err(inst_err),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_en(data_wr_en),
    .data_req(data_req), .data_rd_data(data_rd_data), .data_done(data_done),
    .data_err(data_err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; inst_addr = 32'h0; inst_req = 1'b0; inst_flush = 1'b0;
    data_addr = 32'h0; data_wr_data = 32'h0; data_wr_en = 1'b0; data_req = 1'b0;
    mem_ack = 1'b0; mem_rd_data = 32'h0;
    tick(); tick();
    checks++;
    if ({mem_req, mem_wr_en, inst_valid, inst_err, data_done, data_err} !== 6'b000000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {mem_req, mem_wr_en, inst_valid, inst_err, data_done, data_err});
    end
    checks++;
    if ({inst_data, data_rd_data, mem_addr, mem_wr_data} !== 112'h0) begin
      errors++; $display("FAIL reset_data: inst_data=%h rd=%h addr=%h wd=%h expected all 0",
        inst_data, data_rd_data, mem_addr, mem_wr_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    inst_addr = 32'h2000_0002; inst_req = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000_0000 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL fetch_grant: req=%b addr=%h we=%b expected 1 20000000 0",
        mem_req, mem_addr, mem_wr_en);
    end
    tick(); tick();
    mem_ack = 1'b1; mem_rd_data = 32'hABCD_1234;
    checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_wait: valid=%b req=%b expected 0 1", inst_valid, mem_req);
    end
    tick();
    mem_ack = 1'b0; inst_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 16'hABCD || mem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_done: valid=%b data=%h req=%b expected 1 abcd 0",
        inst_valid, inst_data, mem_req);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0 || inst_data !== 16'hABCD) begin
      errors++; $display("FAIL fetch_pulse: valid=%b req=%b data=%h expected 0 0 abcd",
        inst_valid, mem_req, inst_data);
    end
    // Low half-word fetch with an immediate ack
    inst_addr = 32'h0000_1000; inst_req = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rd_data = 32'h5555_7777;
    tick();
    mem_ack = 1'b0; inst_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 16'h7777) begin
      errors++; $display("FAIL fetch_low: valid=%b data=%h expected 1 7777", inst_valid, inst_data);
    end
    tick();
  endtask

  task automatic test_data_rw();
    data_addr = 32'h1234_5677; data_wr_data = 32'hDEAD_BEEF; data_wr_en = 1'b1; data_req = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1234_5677 || mem_wr_data !== 32'hDEAD_BEEF ||
        mem_wr_en !== 1'b1) begin
      errors++; $display("FAIL write_grant: req=%b addr=%h wd=%h we=%b expected 1 12345677 deadbeef 1",
        mem_req, mem_addr, mem_wr_data, mem_wr_en);
    end
    mem_ack = 1'b1; mem_rd_data = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; data_req = 1'b0;
    checks++;
    if (data_done !== 1'b1 || data_rd_data !== 32'h0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL write_done: done=%b rd=%h ivalid=%b expected 1 00000000 0",
        data_done, data_rd_data, inst_valid);
    end
    tick();
    data_addr = 32'h0000_0004; data_wr_en = 1'b0; data_req = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rd_data = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; data_req = 1'b0;
    checks++;
    if (data_done !== 1'b1 || data_rd_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL read_done: done=%b rd=%h expected 1 cafef00d", data_done, data_rd_data);
    end
    tick();
    checks++;
    if (data_done !== 1'b0 || data_rd_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL read_hold: done=%b rd=%h expected 0 cafef00d", data_done, data_rd_data);
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_seq;
    logic       is_inst;
    logic       excl_bad;
    int         g;
    exp_seq = 10'b10_0001_0000;
    excl_bad = 1'b0;
    g = 0;
    inst_addr = 32'h0000_0100; data_addr = 32'h0000_0200; data_wr_en = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; mem_rd_data = 32'h1357_2468;
    for (int c = 0; c < 80 && g < 10; c++) begin
      tick();
      if ((inst_valid + inst_err + data_done + data_err) > 1) excl_bad = 1'b1;
      if (mem_req && !mem_ack) begin
        is_inst = (mem_addr == 32'h0000_0100);
        checks++;
        if (is_inst !== exp_seq[g]) begin
          errors++; $display("FAIL contention_grant%0d: got inst=%b expected inst=%b",
            g, is_inst, exp_seq[g]);
        end
        g++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    tick();
    mem_ack = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    checks++;
    if (g !== 10) begin
      errors++; $display("FAIL contention_count: got %0d grants expected 10", g);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 16'h2468 || excl_bad !== 1'b0) begin
      errors++; $display("FAIL contention_last: valid=%b data=%h excl_bad=%b expected 1 2468 0",
        inst_valid, inst_data, excl_bad);
    end
    tick();
  endtask

  task automatic test_flush();
    inst_addr = 32'h0000_0300; inst_req = 1'b1;
    tick();
    inst_flush = 1'b1;
    tick();
    inst_flush = 1'b0; inst_req = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL flush_drop_req: req=%b expected 1", mem_req);
    end
    mem_ack = 1'b1; mem_rd_data = 32'h9999_8888;
    data_addr = 32'h0000_0400; data_wr_en = 1'b0; data_req = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL flush_ack: valid=%b req=%b expected 0 0", inst_valid, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0400 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL flush_next_data: req=%b addr=%h valid=%b expected 1 00000400 0",
        mem_req, mem_addr, inst_valid);
    end
    mem_ack = 1'b1; mem_rd_data = 32'h0F0F_0F0F;
    tick();
    mem_ack = 1'b0; data_req = 1'b0;
    checks++;
    if (data_done !== 1'b1 || data_rd_data !== 32'h0F0F_0F0F || inst_data !== 16'h2468) begin
      errors++; $display("FAIL flush_data_done: done=%b rd=%h idata=%h expected 1 0f0f0f0f 2468",
        data_done, data_rd_data, inst_data);
    end
    tick();
    // Flush coinciding with the ack
    inst_addr = 32'h0000_0302; inst_req = 1'b1;
    tick();
    mem_ack = 1'b1; inst_flush = 1'b1; mem_rd_data = 32'h4444_3333;
    tick();
    mem_ack = 1'b0; inst_flush = 1'b0; inst_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0 || inst_data !== 16'h2468) begin
      errors++; $display("FAIL flush_same_cycle: valid=%b req=%b data=%h expected 0 0 2468",
        inst_valid, mem_req, inst_data);
    end
    // Stray ack while idle
    tick();
    mem_ack = 1'b1; mem_rd_data = 32'h7070_7070;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, inst_valid, inst_err, data_done, data_err} !== 5'b00000 ||
        data_rd_data !== 32'h0F0F_0F0F) begin
      errors++; $display("FAIL idle_ack: ctrl=%b rd=%h expected 00000 0f0f0f0f",
        {mem_req, inst_valid, inst_err, data_done, data_err}, data_rd_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int  cnt;
    logic done_seen;
    cnt = 0;
    done_seen = 1'b0;
    data_addr = 32'h0000_0500; data_wr_en = 1'b0; data_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (data_done) done_seen = 1'b1;
      if (mem_req) cnt++;
      else break;
    end
    checks++;
    if (cnt !== 255) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected 255", cnt);
    end
    checks++;
    if (data_err !== 1'b1 || data_done !== 1'b0 || done_seen !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err=%b done=%b seen=%b req=%b expected 1 0 0 0",
        data_err, data_done, done_seen, mem_req);
    end
    data_req = 1'b0;
    tick();
    checks++;
    if (data_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: err=%b req=%b expected 0 0", data_err, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    data_addr = 32'h0000_0600; data_wr_data = 32'h7777_AAAA; data_wr_en = 1'b1; data_req = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || data_done !== 1'b0) begin
      errors++; $display("FAIL reset_async: req=%b we=%b addr=%h done=%b expected 0 0 0 0",
        mem_req, mem_wr_en, mem_addr, data_done);
    end
    @(posedge clk);
    tick();
    reset = 1'b1;
    checks++;
    if (mem_req !== 1'b0 || data_done !== 1'b0) begin
      errors++; $display("FAIL reset_hold: req=%b done=%b expected 0 0", mem_req, data_done);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0600 || mem_wr_en !== 1'b1 ||
        mem_wr_data !== 32'h7777_AAAA) begin
      errors++; $display("FAIL reset_regrant: req=%b addr=%h we=%b wd=%h expected 1 00000600 1 7777aaaa",
        mem_req, mem_addr, mem_wr_en, mem_wr_data);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; data_req = 1'b0;
    checks++;
    if (data_done !== 1'b1) begin
      errors++; $display("FAIL reset_done: done=%b expected 1", data_done);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch();
    test_data_rw();
    test_contention();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w0rm_mem_arbiter.md
W0RM_MEM_ARBITER -- requirements
Module: w0rm_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory/data port width.
REQ-003 SHALL have parameter INST_WIDTH, default 16, instruction width; DATA_WIDTH = 2*INST_WIDTH.
REQ-004 SHALL have parameter MAX_DATA_STREAK, default 4, max consecutive data grants while an instruction fetch waits.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait for mem_ack before abort.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-low reset (asserted at 0).
REQ-007 SHALL have instruction ports: inst_addr in ADDR_WIDTH fetch address; inst_req in 1 fetch request; inst_flush in 1 branch flush; inst_data out INST_WIDTH fetched instruction; inst_valid out 1 fetch-done pulse; inst_err out 1 fetch-timeout pulse.
REQ-008 SHALL have data ports: data_addr in ADDR_WIDTH; data_wr_data in DATA_WIDTH; data_wr_en in 1 write (1) / read (0); data_req in 1; data_rd_data out DATA_WIDTH; data_done out 1 completion pulse; data_err out 1 timeout pulse.
REQ-009 SHALL have memory ports: mem_addr out ADDR_WIDTH; mem_wr_data out DATA_WIDTH; mem_wr_en out 1; mem_req out 1; mem_ack in 1; mem_rd_data in DATA_WIDTH.

Function
REQ-010 SHALL implement FSM states IDLE, INST, DATA, DROP; one memory transaction outstanding at most.
REQ-011 Requesters SHALL hold req, addr, wr data/enable stable until their done/valid/err pulse; arbiter samples them only in IDLE.
REQ-012 IDLE: data_req=1 and (inst_req=0 or inst_flush=1 or streak<MAX_DATA_STREAK) -> DATA; else inst_req=1 and inst_flush=0 -> INST; else stay.
REQ-013 Streak counter SHALL increment on each DATA grant while inst_req=1, saturate at MAX_DATA_STREAK, clear on INST grant or any cycle inst_req=0.
REQ-014 Grant SHALL be registered: request seen in IDLE at cycle N -> mem_req=1 with registered mem_addr/mem_wr_data/mem_wr_en at N+1.
REQ-015 mem_req SHALL stay 1 until the cycle mem_ack=1; mem_ack is a single-cycle pulse with mem_rd_data valid that cycle; mem_req=0 the following cycle and FSM returns to IDLE.
REQ-016 INST + mem_ack at cycle M -> inst_valid=1 for exactly one cycle at M+1; inst_data = mem_rd_data[INST_WIDTH-1:0] if inst_addr[1]=0, else mem_rd_data[DATA_WIDTH-1:INST_WIDTH], registered.
REQ-017 mem_addr for fetches SHALL be inst_addr with bits [1:0] forced to 0; data addresses pass unmodified.
REQ-018 DATA + mem_ack at cycle M -> data_done=1 one cycle at M+1; data_rd_data registered from mem_rd_data on reads, held unchanged on writes.
REQ-019 inst_flush=1 in INST before mem_ack -> DROP; mem_req kept 1; ack consumed without inst_valid; then IDLE.
REQ-020 inst_flush=1 in the same cycle as mem_ack in INST SHALL suppress inst_valid.
REQ-021 inst_flush in IDLE, DATA, DROP SHALL have no effect beyond blocking an INST grant that cycle.
REQ-022 Timeout counter SHALL clear on each grant, count each cycle mem_req=1 without ack; reaching TIMEOUT_CYCLES -> mem_req=0, IDLE, one-cycle inst_err (INST) or data_err (DATA), none in DROP.
REQ-023 A mem_ack arriving in IDLE SHALL be ignored.
REQ-024 inst_valid, inst_err, data_done, data_err SHALL never assert simultaneously.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, mem_req=0, mem_wr_en=0, inst_valid=0, inst_err=0, data_done=0, data_err=0, streak=0, timeout count=0.
REQ-026 inst_data, data_rd_data, mem_addr, mem_wr_data SHALL reset to 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it without any done/valid/err pulse; first grant possible on the first clk edge after reset returns to 1.

Verification
REQ-028 Fetch: inst_req=1, inst_addr=0x2000_0002, ack 3 cycles later with mem_rd_data=0xABCD_1234 -> mem_addr=0x2000_0000, inst_valid one cycle, inst_data=0xABCD.
REQ-029 Contention: inst_req and data_req held continuously, 1-cycle ack -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DATA_STREAK=4).
REQ-030 Flush in flight: fetch granted, inst_flush pulsed before ack, ack returns -> no inst_valid, FSM IDLE, next data_req granted next cycle.
REQ-031 Timeout: data read granted, mem_ack held 0 -> after 255 cycles mem_req=0, data_err one cycle, data_done never.
REQ-032 Reset mid-write: reset=0 during DATA with mem_req=1 -> mem_req=0 asynchronously, no data_done; after release, held data_req re-granted.
